// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the APB UART transmitter peripheral.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_W = 8;

  // Register indices as decoded from PADDR[3:2]
  localparam logic [1:0] REG_CR  = 2'd0;
  localparam logic [1:0] REG_SR  = 2'd1;
  localparam logic [1:0] REG_TDR = 2'd2;

  // Status register bit positions
  localparam int unsigned SR_FULL    = 0;
  localparam int unsigned SR_EMPTY   = 1;
  localparam int unsigned SR_BUSY    = 2;
  localparam int unsigned SR_OVF     = 3;
  localparam int unsigned SR_CNT_LSB = 4;
  localparam int unsigned SR_CNT_W   = 4;

endpackage

// File: rtl/apb_uart_tx_periph_fifo.sv
// Small synchronous FIFO holding bytes waiting for transmission.
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Extra pointer MSB distinguishes full from empty when addresses match
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer update; a push while full is dropped even if a pop happens too
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + PW'(1);
      if (pop_i && !empty_o) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/apb_uart_tx_periph.sv
// APB responder that queues CPU bytes and sends them as 8N1 UART frames.
module apb_uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned CNT_W   = $clog2(BIT_CYC);
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;

  // Registers
  logic              pready_q;
  logic [31:0]       prdata_q;
  logic              en_q;
  logic              ovf_q;
  logic              ovf_d;
  logic              tx_q;
  tx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  // APB decode
  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic [1:0]  reg_idx;
  logic [31:0] sr_val;
  logic [31:0] rdata;
  logic        busy;
  logic        bit_end;

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:8]};

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign tx      = tx_q;

  assign access  = PSEL && PENABLE && !pready_q;
  assign wr_acc  = access && PWRITE;
  assign rd_acc  = access && !PWRITE;
  assign reg_idx = PADDR[3:2];
  assign busy    = (state_q != IDLE);
  assign bit_end = (cnt_q == CNT_W'(BIT_CYC - 1));

  assign fifo_push = wr_acc && (reg_idx == REG_TDR);
  // Pop when a new frame can start: from IDLE, or straight out of the stop bit
  assign fifo_pop  = en_q && !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (PWDATA[DATA_W-1:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Status word and read-data mux
  always_comb begin
    sr_val                           = '0;
    sr_val[SR_FULL]                  = fifo_full;
    sr_val[SR_EMPTY]                 = fifo_empty;
    sr_val[SR_BUSY]                  = busy;
    sr_val[SR_OVF]                   = ovf_q;
    sr_val[SR_CNT_LSB +: SR_CNT_W]   = SR_CNT_W'(fifo_count);
    unique case (reg_idx)
      REG_CR:  rdata = {31'd0, en_q};
      REG_SR:  rdata = sr_val;
      default: rdata = '0;
    endcase
  end

  // Sticky overflow: a dropped push beats a same-cycle SR read clear
  always_comb begin
    ovf_d = ovf_q;
    if (rd_acc && (reg_idx == REG_SR)) ovf_d = 1'b0;
    if (fifo_push && fifo_full)        ovf_d = 1'b1;
  end

  // APB handshake, control register and overflow flag
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pready_q <= access;
      if (access) prdata_q <= rdata;
      if (wr_acc && (reg_idx == REG_CR)) en_q <= PWDATA[0];
      ovf_q <= ovf_d;
    end
  end

  // Transmit FSM with baud counter; tx follows the state one cycle later
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE:    tx_q <= 1'b1;
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fifo_pop) begin
            state_q <= START;
            shift_q <= fifo_dout;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (fifo_pop) begin
              state_q <= START;
              shift_q <= fifo_dout;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx_periph.sv
// Self-checking bench for apb_uart_tx_periph with a queue-based reference model.
module tb_apb_uart_tx_periph;

  localparam int unsigned BIT_CYC = 10;
  localparam int unsigned FRAME   = 10 * BIT_CYC;
  localparam int unsigned DEPTH   = 8;

  logic        PCLK;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Reference model: bytes accepted but not yet transmitted, plus sticky overflow
  logic [7:0] mdl_q[$];
  bit         mdl_ovf;

  apb_uart_tx_periph #(
    .CLK_HZ     (100_000_000),
    .BAUD       (10_000_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tx      (tx)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected SR value derived from the model queue
  function automatic logic [31:0] sr_model(input bit busy);
    int n;
    logic [31:0] r;
    n = mdl_q.size();
    r = 32'(n) << 4;
    if (mdl_ovf)    r[3] = 1'b1;
    if (busy)       r[2] = 1'b1;
    if (n == 0)     r[1] = 1'b1;
    if (n == DEPTH) r[0] = 1'b1;
    return r;
  endfunction

  // Model of a TDR write performed while transmission is disabled
  function automatic void mdl_push(input logic [7:0] b);
    if (mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
    else                       mdl_q.push_back(b);
  endfunction

  // Ideal line waveform: start 0, data LSB first, stop 1, each bit BIT_CYC cycles
  function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
    logic [9:0]       f;
    logic [FRAME-1:0] w;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < FRAME; k++) w[k] = f[k / BIT_CYC];
    return w;
  endfunction

  // One APB transfer; a missing or late PREADY counts as a miscompare
  task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int waits;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    do begin
      @(posedge PCLK); #1;
      waits++;
    end while (PREADY !== 1'b1 && waits < 8);
    vectors++;
    if (PREADY !== 1'b1 || waits != 1) begin
      miscompares++;
      $display("FAIL apb_handshake addr=%h: pready=%b after %0d cycles, required 1 after 1", addr, PREADY, waits);
    end
    rdata = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    apb_xfer(addr, 1'b1, wdata, dummy);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] rdata);
    apb_xfer(addr, 1'b0, 32'd0, rdata);
  endtask

  // Waits (bounded) for a start bit, then records the whole frame cycle by cycle
  task automatic capture_frame(input int budget, output logic [FRAME-1:0] seq,
                               output int t0, output bit found);
    int w;
    w = 0;
    seq = '0;
    while (tx !== 1'b0 && w < budget) begin
      @(posedge PCLK); #1;
      w++;
    end
    found = (tx === 1'b0);
    t0 = cyc;
    if (found) begin
      for (int k = 0; k < FRAME; k++) begin
        seq[k] = tx;
        @(posedge PCLK); #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    mdl_q.delete();
    mdl_ovf = 1'b0;
    vectors++;
    if (tx !== 1'b1 || PREADY !== 1'b0 || PRDATA !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: tx=%b pready=%b prdata=%h, required 1 0 0", tx, PREADY, PRDATA);
    end
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL reset_sr: got %h, required 00000002", rd);
    end
    @(posedge PCLK); #1;
    vectors++;
    if (PREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL pready_pulse: pready=%b one cycle later, required 0", PREADY);
    end
    apb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cr: got %h, required 00000000", rd);
    end
  endtask

  task automatic test_single_frame();
    logic [FRAME-1:0] seq;
    logic [31:0]      sr_mid;
    logic [31:0]      rd;
    int               t0;
    bit               found;
    apb_write(32'h0, 32'h1);
    apb_write(32'h8, 32'h0000_00A5);
    fork
      capture_frame(20, seq, t0, found);
      apb_read(32'h4, sr_mid);
    join
    vectors++;
    if (sr_mid !== 32'h0000_0006) begin
      miscompares++;
      $display("FAIL busy_sr: got %h, required 00000006", sr_mid);
    end
    vectors++;
    if (!found || seq !== frame_wave(8'hA5)) begin
      miscompares++;
      $display("FAIL frame_a5: found=%0d wave=%h, required %h", found, seq, frame_wave(8'hA5));
    end
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL post_frame_sr: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [7:0]  b;
    apb_write(32'h0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      mdl_push(b);
      apb_write(32'h8, {24'($urandom), b});
    end
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0000_0089 || rd !== sr_model(1'b0)) begin
      miscompares++;
      $display("FAIL ovf_sr: got %h, required 00000089", rd);
    end
    mdl_ovf = 1'b0;
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0000_0081) begin
      miscompares++;
      $display("FAIL ovf_cleared_sr: got %h, required 00000081", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [FRAME-1:0] seq;
    logic [FRAME-1:0] exp;
    logic [31:0]      rd;
    int               t0;
    int               t_prev;
    bit               found;
    apb_write(32'h0, 32'h1);
    t_prev = 0;
    for (int i = 0; mdl_q.size() > 0; i++) begin
      exp = frame_wave(mdl_q.pop_front());
      capture_frame(20, seq, t0, found);
      vectors++;
      if (!found || seq !== exp) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: found=%0d wave=%h, required %h", i, found, seq, exp);
      end
      if (i > 0) begin
        vectors++;
        if (t0 - t_prev != FRAME) begin
          miscompares++;
          $display("FAIL b2b_gap%0d: start spacing %0d cycles, required %0d", i, t0 - t_prev, FRAME);
        end
      end
      t_prev = t0;
    end
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== sr_model(1'b0)) begin
      miscompares++;
      $display("FAIL b2b_done_sr: got %h, required %h", rd, sr_model(1'b0));
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int          w;
    int          highs;
    apb_write(32'h8, 32'h3C);
    apb_write(32'h8, 32'h11);
    apb_write(32'h8, 32'h22);
    w = 0;
    while (tx !== 1'b0 && w < 30) begin
      @(posedge PCLK); #1;
      w++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_start: tx=%b, required start bit 0", tx);
    end
    repeat (35) @(posedge PCLK);
    #1 PRESET = 1'b1;
    @(posedge PCLK); #1;
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_reset_tx: tx=%b, required 1", tx);
    end
    PRESET = 1'b0;
    mdl_q.delete();
    mdl_ovf = 1'b0;
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL midframe_sr: got %h, required 00000002", rd);
    end
    apb_write(32'h0, 32'h1);
    highs = 0;
    for (int k = 0; k < 150; k++) begin
      @(posedge PCLK); #1;
      if (tx === 1'b1) highs++;
    end
    vectors++;
    if (highs != 150) begin
      miscompares++;
      $display("FAIL fifo_discard: tx high %0d of 150 cycles, required 150", highs);
    end
  endtask

  task automatic test_reserved();
    logic [31:0] rd;
    apb_read(32'hC, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL reg3_read: got %h, required 00000000", rd);
    end
    apb_read(32'h8, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL tdr_read: got %h, required 00000000", rd);
    end
    apb_write(32'hC, 32'h0000_0000);
    apb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++;
      $display("FAIL reg3_write_cr1: got %h, required 00000001", rd);
    end
    apb_write(32'h0, 32'h0);
    apb_write(32'hC, 32'hFFFF_FFFF);
    apb_read(32'h0, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL reg3_write_cr0: got %h, required 00000000", rd);
    end
    apb_read(32'h4, rd);
    vectors++;
    if (rd !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL reg3_write_sr: got %h, required 00000002", rd);
    end
  endtask

  task automatic test_random();
    logic [FRAME-1:0] seq;
    logic [FRAME-1:0] exp;
    logic [31:0]      rd;
    logic [31:0]      addr;
    logic [7:0]       b;
    int               n;
    int               t0;
    bit               found;
    for (int it = 0; it < 3; it++) begin
      apb_write(32'h0, 32'h0);
      n = int'($urandom_range(1, 11));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        mdl_push(b);
        addr = ($urandom & 32'hFFFF_FFF3) | 32'h8;
        apb_write(addr, {24'($urandom), b});
      end
      addr = ($urandom & 32'hFFFF_FFF3) | 32'h4;
      apb_read(addr, rd);
      vectors++;
      if (rd !== sr_model(1'b0)) begin
        miscompares++;
        $display("FAIL rand%0d_sr: got %h, required %h", it, rd, sr_model(1'b0));
      end
      mdl_ovf = 1'b0;
      apb_write(32'h0, 32'h1);
      while (mdl_q.size() > 0) begin
        exp = frame_wave(mdl_q.pop_front());
        capture_frame(20, seq, t0, found);
        vectors++;
        if (!found || seq !== exp) begin
          miscompares++;
          $display("FAIL rand%0d_frame: found=%0d wave=%h, required %h", it, found, seq, exp);
        end
      end
      apb_read(32'h4, rd);
      vectors++;
      if (rd !== sr_model(1'b0)) begin
        miscompares++;
        $display("FAIL rand%0d_done_sr: got %h, required %h", it, rd, sr_model(1'b0));
      end
    end
  endtask

  initial begin
    PRESET  = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    mdl_ovf = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_reserved();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
